// File: rtl/elevator_pkg.sv
// Shared constants and types for the elevator call scheduler slice.
package elevator_pkg;

    localparam int NUM_FLOORS = 8;
    localparam int FLOOR_W    = $clog2(NUM_FLOORS);

    typedef logic [FLOOR_W-1:0] floor_t;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        TRAVEL,
        DWELL
    } sched_state_t;

endpackage

// File: rtl/elevator_call_scheduler_if.sv
// Link between the scheduler (master) and the Elevator core (slave).
interface elevator_call_scheduler_if #(
    parameter int FLOOR_W = elevator_pkg::FLOOR_W
);

    logic [FLOOR_W-1:0] floor_no;
    logic               ip;
    logic [FLOOR_W-1:0] curr_floor;
    logic               door;

    modport master (
        output floor_no,
        output ip,
        input  curr_floor,
        input  door
    );

    modport slave (
        input  floor_no,
        input  ip,
        output curr_floor,
        output door
    );

endinterface

// File: rtl/elevator_scan_select.sv
// Combinational SCAN target picker: nearest pending floor in the current
// direction, otherwise the nearest one in the opposite direction.
module elevator_scan_select #(
    parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
    parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    curr_floor,
    input  logic                  dir_up,
    output logic [FLOOR_W-1:0]    target,
    output logic                  valid,
    output logic                  new_dir_up
);

    logic               has_up;
    logic               has_dn;
    logic [FLOOR_W-1:0] up_floor;
    logic [FLOOR_W-1:0] dn_floor;

    // Lowest pending floor above the car and highest pending floor below it.
    always_comb begin
        has_up   = 1'b0;
        has_dn   = 1'b0;
        up_floor = '0;
        dn_floor = '0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) > curr_floor) && !has_up) begin
                has_up   = 1'b1;
                up_floor = FLOOR_W'(i);
            end
            if (pending[i] && (FLOOR_W'(i) < curr_floor)) begin
                has_dn   = 1'b1;
                dn_floor = FLOOR_W'(i);
            end
        end
    end

    // Prefer the current direction; reverse only when nothing lies ahead.
    always_comb begin
        valid = has_up || has_dn;
        if (dir_up) begin
            target     = has_up ? up_floor : dn_floor;
            new_dir_up = has_up;
        end else begin
            target     = has_dn ? dn_floor : up_floor;
            new_dir_up = !has_dn;
        end
    end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Call collector and SCAN dispatcher sitting upstream of the Elevator core.
module elevator_call_scheduler #(
    parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
    parameter int FLOOR_W    = elevator_pkg::FLOOR_W,
    parameter int DWELL_CYC  = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_FLOORS-1:0]      call_req,
    elevator_call_scheduler_if.master  bus,
    output logic [NUM_FLOORS-1:0]      pending,
    output logic                       dir_up,
    output logic                       busy
);

    import elevator_pkg::*;

    localparam int CNT_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYC - 1);

    sched_state_t          state;
    logic [CNT_W-1:0]      dwell_cnt;
    logic [FLOOR_W-1:0]    target;
    logic                  valid;
    logic                  new_dir_up;
    logic                  here_pending;
    logic                  arrived;
    logic [NUM_FLOORS-1:0] clr_mask;

    function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
        return NUM_FLOORS'(1) << f;
    endfunction

    elevator_scan_select #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_scan (
        .pending    (pending),
        .curr_floor (bus.curr_floor),
        .dir_up     (dir_up),
        .target     (target),
        .valid      (valid),
        .new_dir_up (new_dir_up)
    );

    // Arrival and at-floor call detection against the car's reported position.
    always_comb begin
        here_pending = (int'(bus.curr_floor) < NUM_FLOORS) && pending[bus.curr_floor];
        arrived      = (bus.curr_floor == bus.floor_no) && bus.door;
    end

    // Bit of the floor being served this cycle; it overrides a coincident call.
    always_comb begin
        clr_mask = '0;
        case (state)
            IDLE:     if (here_pending && bus.door) clr_mask = floor_bit(bus.curr_floor);
            TRAVEL:   if (arrived) clr_mask = floor_bit(bus.floor_no);
            DWELL:    if (bus.door) clr_mask = floor_bit(bus.curr_floor);
            default:  clr_mask = '0;
        endcase
    end

    // Scheduler FSM with pending bitmap, dwell counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pending      <= '0;
            bus.floor_no <= '0;
            bus.ip       <= 1'b0;
            dir_up       <= 1'b1;
            busy         <= 1'b0;
            dwell_cnt    <= '0;
        end else begin
            pending <= (pending | call_req) & ~clr_mask;
            bus.ip  <= 1'b0;
            case (state)
                IDLE: begin
                    if (here_pending && bus.door) begin
                        state     <= DWELL;
                        dwell_cnt <= DWELL_LOAD;
                        busy      <= 1'b1;
                    end else if (valid) begin
                        bus.floor_no <= target;
                        dir_up       <= new_dir_up;
                        bus.ip       <= 1'b1;
                        state        <= DISPATCH;
                        busy         <= 1'b1;
                    end
                end
                DISPATCH: state <= TRAVEL;
                TRAVEL: begin
                    if (arrived) begin
                        state     <= DWELL;
                        dwell_cnt <= DWELL_LOAD;
                    end
                end
                DWELL: begin
                    if (dwell_cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Self-checking bench for elevator_call_scheduler: directed table, hand-written
// corner sequences and randomized traffic against a set-based SCAN model.
module tb_elevator_call_scheduler;

    localparam int NF = 8;
    localparam int FW = 3;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NF-1:0] call_req;
    logic [NF-1:0] pending;
    logic          dir_up;
    logic          busy;

    int errors = 0;
    int checks = 0;

    elevator_call_scheduler_if #(.FLOOR_W(FW)) bus ();

    elevator_call_scheduler #(
        .NUM_FLOORS (NF),
        .FLOOR_W    (FW),
        .DWELL_CYC  (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .call_req (call_req),
        .bus      (bus),
        .pending  (pending),
        .dir_up   (dir_up),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Reference model state: set of outstanding floors plus trip/dwell bookkeeping.
    bit [NF-1:0] m_pend;
    int          m_floor;
    bit          m_ip;
    bit          m_dir;
    bit          m_trip;
    int          m_wait;

    int seen[$];
    int seen_dir[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pend  = '0;
        m_floor = 0;
        m_ip    = 0;
        m_dir   = 1;
        m_trip  = 0;
        m_wait  = 0;
    endfunction

    // Pick from sorted lists of pending floors above/below the car.
    function automatic bit scan_ref(input bit [NF-1:0] p, input int cf, input bit dir,
                                    output int tgt, output bit nd);
        int above[$];
        int below[$];
        tgt = 0;
        nd  = dir;
        for (int f = 0; f < NF; f++) begin
            if (p[f] && f > cf) above.push_back(f);
            if (p[f] && f < cf) below.push_back(f);
        end
        if (above.size() == 0 && below.size() == 0) return 0;
        if (dir) begin
            if (above.size() != 0) begin tgt = above[0]; nd = 1; end
            else begin tgt = below[$]; nd = 0; end
        end else begin
            if (below.size() != 0) begin tgt = below[$]; nd = 0; end
            else begin tgt = above[0]; nd = 1; end
        end
        return 1;
    endfunction

    function automatic void model_step(input logic [NF-1:0] call, input int cf, input bit dr);
        int clr = -1;
        int t;
        bit nd;
        if (m_ip) begin
            m_ip   = 0;
            m_trip = 1;
        end else if (m_trip) begin
            if (cf == m_floor && dr) begin
                clr    = m_floor;
                m_trip = 0;
                m_wait = DW;
            end
        end else if (m_wait > 0) begin
            if (dr) clr = cf;
            m_wait--;
        end else if (m_pend[cf] && dr) begin
            clr    = cf;
            m_wait = DW;
        end else if (scan_ref(m_pend, cf, m_dir, t, nd)) begin
            m_floor = t;
            m_dir   = nd;
            m_ip    = 1;
        end
        m_pend = m_pend | call;
        if (clr >= 0) m_pend[clr] = 0;
    endfunction

    // One clock: advance model with the inputs seen at the edge, then compare.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step(call_req, int'(bus.curr_floor), bus.door);
        #1;
        check({tag, ".pending"}, pending, m_pend);
        check({tag, ".ip"}, bus.ip, m_ip);
        check({tag, ".floor_no"}, bus.floor_no, m_floor);
        check({tag, ".dir_up"}, dir_up, m_dir);
        check({tag, ".busy"}, busy, m_ip || m_trip || (m_wait > 0));
        if (bus.ip === 1'b1) begin
            seen.push_back(int'(bus.floor_no));
            seen_dir.push_back(int'(dir_up));
        end
    endtask

    // Stand-in for the Elevator core, following the model's current target.
    task automatic stub(input bit det);
        int car = int'(bus.curr_floor);
        if (m_ip || m_trip) begin
            if (car != m_floor && (det || $urandom_range(2) != 0)) begin
                car      = (car < m_floor) ? car + 1 : car - 1;
                bus.door = 1'b0;
            end else if (car == m_floor) begin
                bus.door = det ? 1'b1 : ($urandom_range(3) != 0);
            end else begin
                bus.door = 1'b0;
            end
        end else if (!det && $urandom_range(15) == 0) begin
            car      = $urandom_range(NF - 1);
            bus.door = 1'b0;
        end else begin
            bus.door = det ? 1'b1 : ($urandom_range(5) != 0);
        end
        bus.curr_floor = FW'(car);
    endtask

    task automatic do_reset(input int car);
        rst_n          = 1'b0;
        call_req       = '0;
        bus.curr_floor = FW'(car);
        bus.door       = 1'b1;
        model_reset();
        seen.delete();
        seen_dir.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [NF-1:0] call;
        int            cf;
        bit            dr;
        bit            ip;
        int            fno;
        logic [NF-1:0] pend;
        bit            busy;
        bit            dir;
    } vec_t;

    vec_t vt[$];

    initial begin
        rst_n = 1'b0;

        // Single call to floor 4 from floor 0, then a call at the current floor 3.
        vt.push_back('{8'h10, 0, 1, 0, 0, 8'h10, 0, 1});
        vt.push_back('{8'h00, 0, 1, 1, 4, 8'h10, 1, 1});
        vt.push_back('{8'h00, 0, 0, 0, 4, 8'h10, 1, 1});
        vt.push_back('{8'h00, 2, 0, 0, 4, 8'h10, 1, 1});
        vt.push_back('{8'h00, 4, 1, 0, 4, 8'h00, 1, 1});
        vt.push_back('{8'h00, 4, 1, 0, 4, 8'h00, 1, 1});
        vt.push_back('{8'h00, 4, 1, 0, 4, 8'h00, 1, 1});
        vt.push_back('{8'h00, 4, 1, 0, 4, 8'h00, 0, 1});
        vt.push_back('{8'h08, 3, 1, 0, 4, 8'h08, 0, 1});
        vt.push_back('{8'h00, 3, 1, 0, 4, 8'h00, 1, 1});
        vt.push_back('{8'h00, 3, 1, 0, 4, 8'h00, 1, 1});
        vt.push_back('{8'h00, 3, 1, 0, 4, 8'h00, 1, 1});
        vt.push_back('{8'h00, 3, 1, 0, 4, 8'h00, 0, 1});

        // Reset: outputs hold reset values for 20 idle cycles.
        do_reset(0);
        for (int c = 0; c < 20; c++) begin
            tick("reset");
        end
        check("reset.ip_const", bus.ip, 1'b0);
        check("reset.pending_const", pending, 8'h00);
        check("reset.dir_const", dir_up, 1'b1);

        // Directed table.
        do_reset(0);
        for (int i = 0; i < vt.size(); i++) begin
            call_req       = vt[i].call;
            bus.curr_floor = FW'(vt[i].cf);
            bus.door       = vt[i].dr;
            @(posedge clk);
            #1;
            check($sformatf("tbl%0d.ip", i), bus.ip, vt[i].ip);
            check($sformatf("tbl%0d.floor_no", i), bus.floor_no, vt[i].fno);
            check($sformatf("tbl%0d.pending", i), pending, vt[i].pend);
            check($sformatf("tbl%0d.busy", i), busy, vt[i].busy);
            check($sformatf("tbl%0d.dir_up", i), dir_up, vt[i].dir);
        end
        call_req = '0;

        // SCAN ordering from floor 2 going up with calls 0, 5, 7.
        do_reset(2);
        call_req = 8'hA1;
        tick("scan");
        call_req = '0;
        stub(1);
        for (int c = 0; c < 200 && seen.size() < 3; c++) begin
            tick("scan");
            stub(1);
        end
        check("scan.count", seen.size(), 3);
        if (seen.size() >= 3) begin
            check("scan.first", seen[0], 5);
            check("scan.second", seen[1], 7);
            check("scan.third", seen[2], 0);
            check("scan.dir_second", seen_dir[1], 1);
            check("scan.dir_third", seen_dir[2], 0);
        end

        // Calls for 6 and 1 arriving while the car travels to 6.
        do_reset(0);
        call_req = 8'h40;
        tick("travel");
        call_req = '0;
        stub(1);
        for (int c = 0; c < 20 && !(m_trip && bus.curr_floor != 0); c++) begin
            tick("travel");
            stub(1);
        end
        call_req = 8'h42;
        tick("travel");
        call_req = '0;
        stub(1);
        for (int c = 0; c < 200 && (seen.size() < 2 || busy); c++) begin
            tick("travel");
            stub(1);
        end
        for (int c = 0; c < 10; c++) begin
            tick("travel_tail");
            stub(1);
        end
        check("travel.count", seen.size(), 2);
        if (seen.size() >= 2) begin
            check("travel.first", seen[0], 6);
            check("travel.second", seen[1], 1);
            check("travel.dir_second", seen_dir[1], 0);
        end

        // Asynchronous reset in TRAVEL with calls 5 and 7 outstanding.
        do_reset(0);
        call_req = 8'hA0;
        tick("midrst");
        call_req = '0;
        stub(1);
        for (int c = 0; c < 20 && !(m_trip && bus.curr_floor >= 2); c++) begin
            tick("midrst");
            stub(1);
        end
        check("midrst.pending_before", pending, 8'hA0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.pending", pending, 8'h00);
        check("midrst.floor_no", bus.floor_no, 3'd0);
        check("midrst.ip", bus.ip, 1'b0);
        check("midrst.busy", busy, 1'b0);
        model_reset();
        seen.delete();
        repeat (2) @(posedge clk);
        bus.door = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick("midrst_after");
        end
        check("midrst.no_ip", seen.size(), 0);

        // Randomized traffic against the model.
        do_reset($urandom_range(NF - 1));
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) call_req = NF'(1) << $urandom_range(NF - 1);
            else if ($urandom_range(15) == 0) call_req = NF'($urandom);
            else call_req = '0;
            tick("rand");
            stub(0);
        end
        call_req = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/elevator_call_scheduler.md
# elevator_call_scheduler

- Collects floor-call button presses into a pending-request bitmap and picks the next target floor with a directional SCAN policy.
- Issues each target to the `Elevator` core as a `floor_no` value with a one-cycle `ip` pulse.
- Sits directly upstream of `Elevator`. It drives that block's `floor_no`/`ip` inputs and consumes its `curr_floor`/`door` outputs to know when a request has been served.

## Interface
- `NUM_FLOORS`, default 8: number of floors served.
- `FLOOR_W`, default 3: width of floor numbers, equal to `$clog2(NUM_FLOORS)`.
- `DWELL_CYC`, default 3: cycles the scheduler waits after arrival before dispatching again.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `call_req`  in  NUM_FLOORS: floor-call buttons. A bit high in any cycle registers a call for that floor.
- `curr_floor`  in  FLOOR_W: current floor reported by `Elevator`.
- `door`  in  1: door-open indication from `Elevator`; 1 means the car is stopped at `curr_floor`.
- `floor_no`  out  FLOOR_W: target floor sent to `Elevator`. Held stable between dispatches.
- `ip`  out  1: one-cycle dispatch strobe.
- `pending`  out  NUM_FLOORS: registered bitmap of outstanding calls.
- `dir_up`  out  1: current SCAN direction; 1 = up.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- **Reset values:** state IDLE; `pending`=0; `floor_no`=0; `ip`=0; `dir_up`=1; `busy`=0; dwell counter 0.
- **Pending update, every cycle:** `pending <= (pending | call_req) & ~clr_mask`.
  - `clr_mask` is the served floor's bit in the cycle it is served.
  - If set and clear coincide on the same bit, clear wins. The call is already being served.
- **SCAN select (combinational):**
  - `dir_up`=1: the target is the lowest pending floor above `curr_floor`. If none exists, the target is the highest pending floor below `curr_floor`, and `dir_up` flips to 0 on dispatch.
  - `dir_up`=0: mirror image of the above.
  - Floor `curr_floor` itself is never selected.
- **FSM states:**
  - **IDLE.**
    - If `pending[curr_floor]` is set and `door`=1, clear it in place and go to DWELL, with no dispatch.
    - Otherwise, if any pending bit is set, latch the SCAN target into `floor_no`, update `dir_up`, and go to DISPATCH.
    - If no bit is pending, stay in IDLE.
  - **DISPATCH.** `ip`=1 for exactly this cycle, then go to TRAVEL.
  - **TRAVEL.** Wait for `curr_floor==floor_no && door==1`. On that cycle, clear `pending[floor_no]`, load the dwell counter with `DWELL_CYC-1`, and go to DWELL.
    - Calls arriving during TRAVEL only set bits; the target is not re-planned mid-trip.
  - **DWELL.** Decrement the counter; on reaching 0, go to IDLE.
    - Calls for `curr_floor` arriving while `door`=1 in DWELL are absorbed and cleared in the same cycle.
- **Widths:** all floor comparisons are unsigned at `FLOOR_W` bits.
  - Bits of `call_req` above `NUM_FLOORS-1` do not exist.
  - `floor_no` never exceeds `NUM_FLOORS-1`.
- **Reset mid-operation:** asynchronously returns to the reset values; all pending calls are discarded. `ip` must not glitch high on reset release.

## Timing
- `call_req` bit high in cycle n: `pending` shows it in cycle n+1.
- Earliest `ip` is in cycle n+2, with `floor_no` valid in that same cycle.
- `ip` is registered (decoded from the DISPATCH state): high one cycle, never two consecutive cycles.
- Minimum spacing between two `ip` pulses is 2 + `DWELL_CYC` cycles after arrival is detected.
- Arrival detection has 1-cycle latency: the clear takes effect on the edge after `curr_floor==floor_no && door==1` is seen.

## Structure
- Shared package `elevator_pkg` holds:
  - `NUM_FLOORS` and `FLOOR_W` constants;
  - `sched_state_t` enum (IDLE, DISPATCH, TRAVEL, DWELL);
  - the floor type `logic [FLOOR_W-1:0]`.
- One sub-module, `elevator_scan_select`. It is purely combinational: inputs `pending`, `curr_floor`, `dir_up`; outputs `target`, `valid`, `new_dir_up`.
- The FSM, pending register, and dwell counter stay in the top module.

## Test plan
- **Reset:** release `rst_n`. All outputs hold their reset values with `ip`=0 for 20 cycles and `call_req`=0.
- **Single call:** car at floor 0 with `door`=1; pulse `call_req[4]` in cycle n. `ip`=1 in cycle n+2 with `floor_no`=4. `pending[4]` clears one cycle after the stubbed `Elevator` reports `curr_floor`=4 with `door`=1.
- **SCAN ordering:** car at floor 2 with `dir_up`=1; calls 0, 5, 7 registered together. Dispatch order is 5, 7, 0, and `dir_up` drops to 0 at the third dispatch.
- **Call at current floor:** IDLE at floor 3 with `door`=1; pulse `call_req[3]`. No `ip` occurs, `pending[3]` clears, and `busy` stays high for `DWELL_CYC` cycles.
- **Call during TRAVEL:** target 6 in flight; pulse `call_req[6]` and `call_req[1]`. Exactly one `ip` goes to 6. After dwell, `ip` goes to 1 with `dir_up`=0.
- **Mid-operation reset:** assert `rst_n`=0 in TRAVEL with `pending`=8'b1010_0000. `pending`, `floor_no`, and `ip` are 0 immediately, with no stray `ip` after release.
